pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline stage register for the CPU (D/E, E/M, M/W).

---
 rtl/cpu_pipe_pkg.sv | 18 +
 rtl/pipe_skid_buf.sv | 59 +++++
 rtl/pipe_stage_reg.sv | 61 ++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared stage payload widths, ctrl bit positions and skid buffer state codes
package cpu_pipe_pkg;
  localparam int DE_DATA_W = 107;
  localparam int DE_CTRL_W = 6;
  localparam int EM_DATA_W = 69;
  localparam int EM_CTRL_W = 3;
  localparam int MW_DATA_W = 69;
  localparam int MW_CTRL_W = 2;
  localparam int CTRL_WREG = 0;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WMEM = 2;
  localparam int CTRL_JAL = 3;
  localparam int CTRL_ALUIMM = 4;
  localparam int CTRL_SHIFT = 5;
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry skid buffer with registered in_ready and flush
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DE_DATA_W,
  parameter int CTRL_W = DE_CTRL_W
)(
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic [1:0] st, st_nx;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic in_xfer;
  assign out_valid = st != S_EMPTY;
  assign in_xfer = in_valid & in_ready;
  always_comb
    st_nx = flush ? S_EMPTY
          : st == S_EMPTY ? (in_xfer ? S_ONE : S_EMPTY)
          : st == S_ONE ? (in_xfer ? (out_ready ? S_ONE : S_FULL) : (out_ready ? S_EMPTY : S_ONE))
          : out_ready ? S_ONE : S_FULL;
  always_ff @(posedge clk)
    if (clr) begin
      st <= S_EMPTY;
      in_ready <= 1'b1;
      out_data <= '0;
      out_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      st <= st_nx;
      in_ready <= st_nx != S_FULL;
      if (!flush) begin
        if (st == S_FULL) begin
          if (out_ready) begin
            out_data <= skid_data;
            out_ctrl <= skid_ctrl;
          end
        end else if (in_xfer) begin
          if (st == S_EMPTY || out_ready) begin
            out_data <= in_data;
            out_ctrl <= in_ctrl;
          end else begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
        end
      end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with handshake, flush, bubble masking, optional skid and stall counter
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DE_DATA_W,
  parameter int CTRL_W = DE_CTRL_W,
  parameter int SKID = 1,
  parameter int CNT_W = 16
)(
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [CTRL_W-1:0] ctrl_reg;
  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_buf (
        .clk(clk),
        .clr(clr),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_ctrl(in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ctrl(ctrl_reg)
      );
    end else begin : g_reg
      assign in_ready = out_ready | ~out_valid;
      always_ff @(posedge clk)
        if (clr) begin
          out_valid <= 1'b0;
          out_data <= '0;
          ctrl_reg <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (in_valid & in_ready) begin
          out_valid <= 1'b1;
          out_data <= in_data;
          ctrl_reg <= in_ctrl;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
    end
  endgenerate
  assign out_ctrl = out_valid ? ctrl_reg : '0;
  always_ff @(posedge clk)
    if (clr) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks skid and plain stage variants against a FIFO reference model plus vector table
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic clr, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [5:0] in_ctrl;
  logic [1:0] ov, ir;
  logic [1:0][15:0] od;
  logic [1:0][5:0] oc;
  logic [1:0][3:0] sc;
  int n_tests = 0;
  int n_fail = 0;
  logic [21:0] mq [2][2];
  int mn [2];
  int mc [2];
  typedef struct {
    logic iv;
    logic [15:0] id;
    logic [5:0] ic;
    logic ordy;
    logic ev;
    logic [15:0] ed;
    logic [5:0] ec;
    logic eir;
    logic [3:0] ecnt;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(1), .CNT_W(4)) dut_skid (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc[0])
  );
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(0), .CNT_W(4)) dut_reg (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage is a FIFO of capacity 2 (skid) or 1 (plain); compare at negedge, then advance model.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic rdy;
      rdy = k == 0 ? (mn[k] < 2) : (mn[k] == 0 || out_ready);
      chk($sformatf("d%0d_out_valid", k), 32'(ov[k]), 32'(mn[k] > 0));
      chk($sformatf("d%0d_in_ready", k), 32'(ir[k]), 32'(rdy));
      chk($sformatf("d%0d_out_ctrl", k), 32'(oc[k]), mn[k] > 0 ? 32'(mq[k][0][5:0]) : 32'd0);
      if (mn[k] > 0) chk($sformatf("d%0d_out_data", k), 32'(od[k]), 32'(mq[k][0][21:6]));
      chk($sformatf("d%0d_stall_cnt", k), 32'(sc[k]), 32'(mc[k]));
      if (clr) begin
        mn[k] = 0;
        mc[k] = 0;
      end else if (flush) begin
        mn[k] = 0;
      end else begin
        if (mn[k] > 0 && !out_ready && mc[k] != 15) mc[k]++;
        if (mn[k] > 0 && out_ready) begin
          mq[k][0] = mq[k][1];
          mn[k]--;
        end
        if (in_valid && rdy && mn[k] < 2) begin
          mq[k][mn[k]] = {in_data, in_ctrl};
          mn[k]++;
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    adv();
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic [5:0] c, input logic ordy);
    in_valid = iv;
    in_data = d;
    in_ctrl = c;
    out_ready = ordy;
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h000A, 6'h01, 1'b1, 1'b0, 16'h0000, 6'h00, 1'b1, 4'd0};
    tbl[1] = '{1'b1, 16'h000B, 6'h02, 1'b0, 1'b1, 16'h000A, 6'h01, 1'b1, 4'd0};
    tbl[2] = '{1'b1, 16'h000C, 6'h04, 1'b0, 1'b1, 16'h000A, 6'h01, 1'b0, 4'd1};
    tbl[3] = '{1'b1, 16'h000C, 6'h04, 1'b0, 1'b1, 16'h000A, 6'h01, 1'b0, 4'd2};
    tbl[4] = '{1'b1, 16'h000C, 6'h04, 1'b1, 1'b1, 16'h000A, 6'h01, 1'b0, 4'd3};
    tbl[5] = '{1'b1, 16'h000C, 6'h04, 1'b1, 1'b1, 16'h000B, 6'h02, 1'b1, 4'd3};
    tbl[6] = '{1'b0, 16'h0000, 6'h00, 1'b1, 1'b1, 16'h000C, 6'h04, 1'b1, 4'd3};
    tbl[7] = '{1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 16'h0000, 6'h00, 1'b1, 4'd3};
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      mc[k] = 0;
    end
    clr = 1'b1;
    flush = 1'b0;
    drive(1'b1, 16'h1234, 6'h3F, 1'b0);
    adv();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_d%0d_data", k), 32'(od[k]), 32'd0);
      chk($sformatf("rst_d%0d_ready", k), 32'(ir[k]), 32'd1);
    end
    adv();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 16'(i + 1), 6'h3F, 1'b1);
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stream_d%0d_valid_%0d", k, i), 32'(ov[k]), 32'(i >= 1 && i <= 8));
        if (i >= 1 && i <= 8) chk($sformatf("stream_d%0d_data_%0d", k, i), 32'(od[k]), 32'(i));
      end
      adv();
    end
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy);
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(ov[0]), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(od[0]), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_ctrl", i), 32'(oc[0]), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_in_ready", i), 32'(ir[0]), 32'(tbl[i].eir));
      chk($sformatf("tbl%0d_stall_cnt", i), 32'(sc[0]), 32'(tbl[i].ecnt));
      adv();
    end
    drive(1'b1, 16'h0011, 6'h3F, 1'b0);
    step();
    drive(1'b1, 16'h0022, 6'h3F, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 16'h00DD, 6'h3F, 1'b0);
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0000, 6'h00, 1'b1);
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("flush_d%0d_valid_%0d", k, i), 32'(ov[k]), 32'd0);
        chk($sformatf("flush_d%0d_ctrl_%0d", k, i), 32'(oc[k]), 32'd0);
        chk($sformatf("flush_d%0d_ready_%0d", k, i), 32'(ir[k]), 32'd1);
      end
      adv();
    end
    drive(1'b1, 16'h0033, 6'h09, 1'b0);
    step();
    drive(1'b0, 16'h0000, 6'h00, 1'b0);
    for (int i = 0; i < 20; i++) step();
    tick();
    chk("sat_d0", 32'(sc[0]), 32'd15);
    chk("sat_d1", 32'(sc[1]), 32'd15);
    adv();
    for (int i = 0; i < 5; i++) step();
    tick();
    chk("sat_hold_d0", 32'(sc[0]), 32'd15);
    adv();
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b0, 16'h0000, 6'h00, 1'b1);
    tick();
    chk("sat_clr_d0", 32'(sc[0]), 32'd0);
    chk("sat_clr_d1", 32'(sc[1]), 32'd0);
    adv();
    drive(1'b1, 16'h0044, 6'h3F, 1'b0);
    step();
    drive(1'b1, 16'h0055, 6'h3F, 1'b0);
    step();
    clr = 1'b1;
    flush = 1'b1;
    step();
    clr = 1'b0;
    flush = 1'b0;
    drive(1'b0, 16'h0000, 6'h00, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_d%0d_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("midrst_d%0d_data", k), 32'(od[k]), 32'd0);
      chk($sformatf("midrst_d%0d_ctrl", k), 32'(oc[k]), 32'd0);
      chk($sformatf("midrst_d%0d_cnt", k), 32'(sc[k]), 32'd0);
      chk($sformatf("midrst_d%0d_ready", k), 32'(ir[k]), 32'd1);
    end
    adv();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 16'($urandom), 6'($urandom), ($urandom % 3) != 0);
      flush = ($urandom % 16) == 0;
      clr = ($urandom % 64) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
